ccu_raster: RTL and testbench



---
 rtl/ccu_pkg.sv | 21 ++
 rtl/line_stepper.sv | 88 ++++++++
 rtl/ccu_raster.sv | 143 ++++++++++++++
 tb/tb_ccu_raster.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccu_pkg.sv
// Shared definitions for the Turbo_GRAFIX command control unit.
// Holds the opcode constants, the control FSM state type and the
// helper that converts a field width into a byte count.
package ccu_pkg;

    localparam logic [7:0] OP_POINT = 8'h50;
    localparam logic [7:0] OP_LINE  = 8'h4C;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PARAM = 2'd1,
        SETUP = 2'd2,
        DRAW  = 2'd3
    } state_t;

    // Number of little-endian bytes needed to carry a field of 'width' bits.
    function automatic int unsigned nbytes(input int unsigned width);
        return (width + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/line_stepper.sv
// Bresenham datapath covering all eight octants.
// load    : latch the segment end points and compute dx, dy, err, sx, sy
// advance : step one pixel along the segment (clears last on the final pixel)
// x, y    : current pixel position (registered)
// last    : current pixel is the segment end point (registered)
module line_stepper #(
    parameter int unsigned COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] xs,
    input  logic [COORD_W-1:0] ys,
    input  logic [COORD_W-1:0] xe,
    input  logic [COORD_W-1:0] ye,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    localparam int unsigned AW = COORD_W + 2;

    logic signed [AW-1:0] dx_q, dy_q, err_q;
    logic                 sx_q, sy_q;
    logic [COORD_W-1:0]   xe_q, ye_q;

    logic signed [AW-1:0] ddx, ddy, adx, ady;
    logic signed [AW-1:0] e2, err_n;
    logic                 step_x, step_y;
    logic [COORD_W-1:0]   x_n, y_n;

    // Setup terms: signed deltas and their magnitudes.
    always_comb begin
        ddx = $signed({2'b00, xe}) - $signed({2'b00, xs});
        ddy = $signed({2'b00, ye}) - $signed({2'b00, ys});
        adx = ddx[AW-1] ? -ddx : ddx;
        ady = ddy[AW-1] ? -ddy : ddy;
    end

    // One Bresenham step; both axis updates use the same e2.
    always_comb begin
        e2     = err_q <<< 1;
        step_x = (e2 >= dy_q);
        step_y = (e2 <= dx_q);
        err_n  = err_q + (step_x ? dy_q : AW'(0)) + (step_y ? dx_q : AW'(0));
        x_n    = x;
        y_n    = y;
        if (step_x) x_n = sx_q ? (x + COORD_W'(1)) : (x - COORD_W'(1));
        if (step_y) y_n = sy_q ? (y + COORD_W'(1)) : (y - COORD_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            last  <= 1'b0;
            dx_q  <= '0;
            dy_q  <= '0;
            err_q <= '0;
            sx_q  <= 1'b0;
            sy_q  <= 1'b0;
            xe_q  <= '0;
            ye_q  <= '0;
        end else if (load) begin
            x     <= xs;
            y     <= ys;
            xe_q  <= xe;
            ye_q  <= ye;
            dx_q  <= adx;
            dy_q  <= -ady;
            err_q <= adx - ady;
            sx_q  <= ~ddx[AW-1];
            sy_q  <= ~ddy[AW-1];
            last  <= (xs == xe) && (ys == ye);
        end else if (advance) begin
            if (last) begin
                last <= 1'b0;
            end else begin
                x     <= x_n;
                y     <= y_n;
                err_q <= err_n;
                last  <= (x_n == xe_q) && (y_n == ye_q);
            end
        end
    end

endmodule

// File: rtl/ccu_raster.sv
// Command control unit: collects byte-serial point/line commands and
// rasterises them into a valid/ready pixel stream.
// cmd_data/cmd_valid/cmd_ready : command byte stream in
// pix_x/pix_y/pix_color/pix_last/pix_valid/pix_ready : pixel stream out
// busy : command in progress, err : one-cycle pulse on unknown opcode
module ccu_raster
    import ccu_pkg::*;
#(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned COLOR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         cmd_data,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_last,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               busy,
    output logic               err
);

    localparam int unsigned CB    = nbytes(COORD_W);
    localparam int unsigned KB    = nbytes(COLOR_W);
    localparam int unsigned MAXB  = 4 * CB + KB;
    localparam int unsigned PT_B  = 2 * CB + KB;
    localparam int unsigned CNT_W = $clog2(MAXB + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 is_line_q;
    logic [8*MAXB-1:0]    pbuf_q;

    logic                 cmd_fire, pix_fire, last_byte, op_ok;
    logic                 load, advance, bad_op;
    logic [COORD_W-1:0]   xs_f, ys_f, xe_f, ye_f;
    logic [COLOR_W-1:0]   color_f;
    logic                 unused_pbuf;

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign pix_fire    = pix_valid && pix_ready;
    assign op_ok       = (cmd_data == OP_POINT) || (cmd_data == OP_LINE);
    assign last_byte   = (cnt_q == (is_line_q ? CNT_W'(MAXB - 1) : CNT_W'(PT_B - 1)));
    assign unused_pbuf = ^pbuf_q;

    // Field extraction; a point reuses its start point as the end point.
    always_comb begin
        xs_f = pbuf_q[0      +: COORD_W];
        ys_f = pbuf_q[8*CB   +: COORD_W];
        if (is_line_q) begin
            xe_f    = pbuf_q[16*CB +: COORD_W];
            ye_f    = pbuf_q[24*CB +: COORD_W];
            color_f = pbuf_q[32*CB +: COLOR_W];
        end else begin
            xe_f    = xs_f;
            ye_f    = ys_f;
            color_f = pbuf_q[16*CB +: COLOR_W];
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        bad_op  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (op_ok) state_d = PARAM;
                    else       bad_op  = 1'b1;
                end
            end
            PARAM: begin
                if (cmd_fire && last_byte) state_d = SETUP;
            end
            SETUP: begin
                load    = 1'b1;
                state_d = DRAW;
            end
            DRAW: begin
                if (pix_fire) begin
                    advance = 1'b1;
                    if (pix_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, registered handshake outputs and parameter collector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_ready <= 1'b0;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            cnt_q     <= '0;
            is_line_q <= 1'b0;
            pbuf_q    <= '0;
            pix_color <= '0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= (state_d == IDLE) || (state_d == PARAM);
            pix_valid <= (state_d == DRAW);
            busy      <= (state_d != IDLE);
            err       <= bad_op;
            if (state_q == IDLE && cmd_fire) begin
                cnt_q     <= '0;
                is_line_q <= (cmd_data == OP_LINE);
            end
            if (state_q == PARAM && cmd_fire) begin
                for (int unsigned i = 0; i < MAXB; i++) begin
                    if (cnt_q == CNT_W'(i)) pbuf_q[8*i +: 8] <= cmd_data;
                end
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (load) pix_color <= color_f;
        end
    end

    line_stepper #(
        .COORD_W (COORD_W)
    ) u_stepper (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .xs      (xs_f),
        .ys      (ys_f),
        .xe      (xe_f),
        .ye      (ye_f),
        .x       (pix_x),
        .y       (pix_y),
        .last    (pix_last)
    );

endmodule

// File: tb/tb_ccu_raster.sv
// Directed bench for ccu_raster: one 8-bit-coordinate instance and one
// 12-bit-coordinate instance sharing the clock, command byte and pix_ready.
module tb_ccu_raster;

    logic        clk;
    logic        rst8, rst12;
    logic [7:0]  cmd_data;
    logic        v8, v12;
    logic        pix_ready;

    logic        rdy8, last8, pv8, busy8, err8;
    logic [7:0]  x8, y8, col8;
    logic        rdy12, last12, pv12, busy12, err12;
    logic [11:0] x12, y12;
    logic [7:0]  col12;

    logic        use12;
    logic        cur_rdy, cur_pv, cur_last, cur_busy, cur_err;
    logic [11:0] cur_x, cur_y;
    logic [7:0]  cur_col;

    int checks = 0;
    int passed = 0;

    ccu_raster #(.COORD_W(8), .COLOR_W(8)) u8 (
        .clk(clk), .rst(rst8), .cmd_data(cmd_data), .cmd_valid(v8), .cmd_ready(rdy8),
        .pix_x(x8), .pix_y(y8), .pix_color(col8), .pix_last(last8), .pix_valid(pv8),
        .pix_ready(pix_ready), .busy(busy8), .err(err8)
    );

    ccu_raster #(.COORD_W(12), .COLOR_W(8)) u12 (
        .clk(clk), .rst(rst12), .cmd_data(cmd_data), .cmd_valid(v12), .cmd_ready(rdy12),
        .pix_x(x12), .pix_y(y12), .pix_color(col12), .pix_last(last12), .pix_valid(pv12),
        .pix_ready(pix_ready), .busy(busy12), .err(err12)
    );

    always #5 clk = ~clk;

    always_comb begin
        cur_rdy  = use12 ? rdy12  : rdy8;
        cur_pv   = use12 ? pv12   : pv8;
        cur_last = use12 ? last12 : last8;
        cur_busy = use12 ? busy12 : busy8;
        cur_err  = use12 ? err12  : err8;
        cur_x    = use12 ? x12    : {4'b0000, x8};
        cur_y    = use12 ? y12    : {4'b0000, y8};
        cur_col  = use12 ? col12  : col8;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks = checks + 1;
        assert (obs === exp_v) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one byte and hold it until the selected instance takes it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        cmd_data = b;
        if (use12) v12 = 1'b1;
        else       v8  = 1'b1;
        n = 0;
        while (!cur_rdy && n < 20) begin
            tick();
            n++;
        end
        check("send_ready", 32'(cur_rdy), 32'd1);
        tick();
        v8  = 1'b0;
        v12 = 1'b0;
    endtask

    task automatic expect_pix(input string tag, input int ex, input int ey, input logic el);
        check({tag, "_valid"}, 32'(cur_pv), 32'd1);
        check({tag, "_x"}, 32'(cur_x), 32'(ex));
        check({tag, "_y"}, 32'(cur_y), 32'(ey));
        check({tag, "_last"}, 32'(cur_last), 32'(el));
        check({tag, "_cmdrdy"}, 32'(cur_rdy), 32'd0);
        tick();
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_idle_valid"}, 32'(cur_pv), 32'd0);
        check({tag, "_idle_rdy"}, 32'(cur_rdy), 32'd1);
        check({tag, "_idle_busy"}, 32'(cur_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        clk = 1'b0; rst8 = 1'b1; rst12 = 1'b1;
        v8 = 1'b0; v12 = 1'b0; cmd_data = 8'h00; pix_ready = 1'b1; use12 = 1'b0;

        // Reset state
        tick();
        check("rst_cmd_ready", 32'(cur_rdy), 32'd0);
        check("rst_pix_valid", 32'(cur_pv), 32'd0);
        check("rst_pix_last", 32'(cur_last), 32'd0);
        check("rst_busy", 32'(cur_busy), 32'd0);
        check("rst_err", 32'(cur_err), 32'd0);
        check("rst_pix_x", 32'(cur_x), 32'd0);
        check("rst_pix_y", 32'(cur_y), 32'd0);
        check("rst_pix_color", 32'(cur_col), 32'd0);
        rst8 = 1'b0; rst12 = 1'b0;
        tick();
        check("post_rst_cmd_ready", 32'(cur_rdy), 32'd1);

        // Point (5,7) colour AA; SETUP cycle then pixel two cycles after last byte
        send_byte(8'h50); send_byte(8'h05); send_byte(8'h07); send_byte(8'hAA);
        check("pt_setup_valid", 32'(cur_pv), 32'd0);
        check("pt_setup_busy", 32'(cur_busy), 32'd1);
        check("pt_setup_rdy", 32'(cur_rdy), 32'd0);
        tick();
        check("pt_color", 32'(cur_col), 32'hAA);
        expect_pix("pt", 5, 7, 1'b1);
        expect_idle("pt");

        // Shallow line (0,0)->(3,1) colour 0F
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h0F);
        tick();
        check("ln_color", 32'(cur_col), 32'h0F);
        expect_pix("ln0", 0, 0, 1'b0);
        expect_pix("ln1", 1, 0, 1'b0);
        expect_pix("ln2", 2, 1, 1'b0);
        expect_pix("ln3", 3, 1, 1'b1);
        expect_idle("ln");

        // Reverse steep line (2,5)->(1,0)
        send_byte(8'h4C); send_byte(8'h02); send_byte(8'h05);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h33);
        tick();
        expect_pix("rv0", 2, 5, 1'b0);
        expect_pix("rv1", 2, 4, 1'b0);
        expect_pix("rv2", 2, 3, 1'b0);
        expect_pix("rv3", 1, 2, 1'b0);
        expect_pix("rv4", 1, 1, 1'b0);
        expect_pix("rv5", 1, 0, 1'b1);
        expect_idle("rv");

        // Diagonal (0,0)->(7,7) under random back-pressure
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h07); send_byte(8'h07); send_byte(8'hC3);
        pix_ready = 1'b0;
        tick();
        k = 0;
        for (int cyc = 0; cyc < 200 && k < 8; cyc++) begin
            check("bp_valid", 32'(cur_pv), 32'd1);
            check("bp_x", 32'(cur_x), 32'(k));
            check("bp_y", 32'(cur_y), 32'(k));
            check("bp_last", 32'(cur_last), (k == 7) ? 32'd1 : 32'd0);
            check("bp_cmdrdy", 32'(cur_rdy), 32'd0);
            check("bp_color", 32'(cur_col), 32'hC3);
            pix_ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (pix_ready) k++;
            tick();
        end
        check("bp_count", 32'(k), 32'd8);
        pix_ready = 1'b1;
        expect_idle("bp");

        // Unknown opcode then a normal point
        send_byte(8'h41);
        check("bad_err_pulse", 32'(cur_err), 32'd1);
        check("bad_busy", 32'(cur_busy), 32'd0);
        check("bad_valid", 32'(cur_pv), 32'd0);
        tick();
        check("bad_err_clear", 32'(cur_err), 32'd0);
        expect_idle("bad");
        send_byte(8'h50); send_byte(8'h01); send_byte(8'h02); send_byte(8'h5A);
        tick();
        check("bpt_color", 32'(cur_col), 32'h5A);
        expect_pix("bpt", 1, 2, 1'b1);
        expect_idle("bpt");

        // 12-bit coordinates: partial command discarded by reset
        use12 = 1'b1;
        send_byte(8'h50); send_byte(8'h01);
        check("w12_partial_busy", 32'(cur_busy), 32'd1);
        rst12 = 1'b1;
        tick();
        check("w12_rst_rdy", 32'(cur_rdy), 32'd0);
        check("w12_rst_busy", 32'(cur_busy), 32'd0);
        rst12 = 1'b0;
        tick();
        check("w12_post_rst_rdy", 32'(cur_rdy), 32'd1);

        // Line x 0x123->0x125 at y 0x045; top-byte nibble F must be ignored
        send_byte(8'h4C); send_byte(8'h23); send_byte(8'hF1); send_byte(8'h45); send_byte(8'h00);
        send_byte(8'h25); send_byte(8'h01); send_byte(8'h45); send_byte(8'h00); send_byte(8'h77);
        tick();
        expect_pix("w12a0", 32'h123, 32'h045, 1'b0);
        check("w12a1_x", 32'(cur_x), 32'h124);
        check("w12a1_valid", 32'(cur_pv), 32'd1);
        rst12 = 1'b1;
        tick();
        check("w12_abort_valid", 32'(cur_pv), 32'd0);
        check("w12_abort_last", 32'(cur_last), 32'd0);
        check("w12_abort_x", 32'(cur_x), 32'd0);
        rst12 = 1'b0;
        tick();
        expect_idle("w12_abort");
        tick();
        check("w12_no_more_pix", 32'(cur_pv), 32'd0);

        // Re-issued command completes
        send_byte(8'h4C); send_byte(8'h23); send_byte(8'hF1); send_byte(8'h45); send_byte(8'h00);
        send_byte(8'h25); send_byte(8'h01); send_byte(8'h45); send_byte(8'h00); send_byte(8'h77);
        tick();
        check("w12_color", 32'(cur_col), 32'h77);
        expect_pix("w12b0", 32'h123, 32'h045, 1'b0);
        expect_pix("w12b1", 32'h124, 32'h045, 1'b0);
        expect_pix("w12b2", 32'h125, 32'h045, 1'b1);
        expect_idle("w12b");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
